// File: rtl/neo_sma_cfg.sv
// neo_sma_cfg: loader-configurable NEO-SMA protection: scrambled-index bank switch, ID register, LFSR RNG.
// The RNG (LFSR, RNG_ADDR1/2 and its read path) is built only when SMA_RNG_EN is defined.
module neo_sma_cfg #(
  parameter int BANK_W = 24,
  parameter int IDX_W  = 6
`ifdef SMA_RNG_EN
  ,
  parameter logic [15:0] LFSR_SEED = 16'h2345,
  parameter logic [15:0] LFSR_TAPS = 16'h98EC
`endif
) (
  input  logic              CLK_24M,
  input  logic              RESET,
  input  logic [18:0]       M68K_ADDR,
  input  logic [15:0]       M68K_DIN,
  output logic [15:0]       M68K_DOUT,
  output logic [1:0]        M68K_DOE,
  input  logic [15:0]       PROM_DATA,
  input  logic              nPORTOEL,
  input  logic              nPORTOEU,
  input  logic              nPORTWEL,
  input  logic              nPORTWEU,
  input  logic              CFG_WE,
  input  logic [6:0]        CFG_ADDR,
  input  logic [23:0]       CFG_DATA,
  output logic [BANK_W-1:0] P2_ADDR,
  output logic              BANK_BUSY,
  output logic [1:0]        BANK_STATE
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BANK_W-1:0]  map_q [DEPTH];
  logic [BANK_W-1:0]  rd_q, bank_q, cpu_off;
  logic [18:0]        bank_addr_q, id_addr_q;
  logic [15:0]        id_val_q;
  logic [4*IDX_W-1:0] idx_sel_q;
  logic               enable_q, we_q, pend_q;
  logic [IDX_W-1:0]   pend_idx_q, cur_idx, start_idx;
  logic               nport_we, bank_fall, start, map_wr;

  assign nport_we  = nPORTWEL & nPORTWEU;
  assign bank_fall = enable_q & we_q & ~nport_we & (M68K_ADDR == bank_addr_q);

  // Each index bit is picked from an arbitrary data bit chosen by IDX_SEL.
  always_comb begin
    cur_idx = '0;
    for (int k = 0; k < IDX_W; k++) cur_idx[k] = M68K_DIN[idx_sel_q[4*k +: 4]];
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_idx = cur_idx;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          start     = 1'b1;
          start_idx = pend_idx_q;
          state_d   = S_LOOKUP;
        end else if (bank_fall) begin
          start   = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign BANK_BUSY  = start | (state_q == S_LOOKUP);
  assign BANK_STATE = state_q;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b1;
      rd_q        <= '0;
      bank_q      <= '0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      bank_addr_q <= '0;
      id_addr_q   <= '0;
      id_val_q    <= '0;
      idx_sel_q   <= '0;
      enable_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= nport_we;
      if (start) rd_q <= map_q[start_idx];
      if (state_q == S_LOOKUP) bank_q <= rd_q;
      // A write arriving while busy (or while a pending one is being launched) waits one-deep; last wins.
      if (bank_fall && (state_q != S_IDLE || pend_q)) begin
        pend_q     <= 1'b1;
        pend_idx_q <= cur_idx;
      end else if (state_q == S_IDLE) begin
        pend_q <= 1'b0;
      end
      if (CFG_WE) begin
        case (CFG_ADDR)
          7'h40:   bank_addr_q <= CFG_DATA[18:0];
          7'h43:   id_addr_q   <= CFG_DATA[18:0];
          7'h44:   id_val_q    <= CFG_DATA[15:0];
          7'h45:   idx_sel_q   <= CFG_DATA[4*IDX_W-1:0];
          7'h46:   enable_q    <= CFG_DATA[0];
          default: ;
        endcase
      end
    end
  end

  // Map RAM keeps its contents across reset; a same-cycle read sees the old word.
  assign map_wr = CFG_WE & ~RESET & ~CFG_ADDR[6] & (int'(CFG_ADDR[5:0]) < DEPTH);

  always_ff @(posedge CLK_24M) begin
    if (map_wr) map_q[CFG_ADDR[IDX_W-1:0]] <= CFG_DATA[BANK_W-1:0];
  end

`ifdef SMA_RNG_EN
  logic [18:0] rng_addr1_q, rng_addr2_q;
  logic [15:0] rng_q;
  logic        oe_q;

  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      rng_q       <= LFSR_SEED;
      rng_addr1_q <= '0;
      rng_addr2_q <= '0;
      oe_q        <= 1'b1;
    end else begin
      oe_q <= nPORTOEL & nPORTOEU;
      if (CFG_WE && CFG_ADDR == 7'h41) rng_addr1_q <= CFG_DATA[18:0];
      if (CFG_WE && CFG_ADDR == 7'h42) rng_addr2_q <= CFG_DATA[18:0];
      if (enable_q && oe_q && !(nPORTOEL & nPORTOEU))
        rng_q <= {rng_q[14:0], ^(rng_q & LFSR_TAPS)};
    end
  end
`endif

  always_comb begin
    M68K_DOUT = PROM_DATA;
`ifdef SMA_RNG_EN
    if (M68K_ADDR == rng_addr1_q || M68K_ADDR == rng_addr2_q) M68K_DOUT = rng_q;
`endif
    if (M68K_ADDR == id_addr_q) M68K_DOUT = id_val_q;
  end

  assign cpu_off  = BANK_W'({M68K_ADDR, 1'b0});
  assign P2_ADDR  = enable_q ? bank_q + cpu_off : cpu_off;
  assign M68K_DOE = enable_q ? ~{nPORTOEU, nPORTOEL} : 2'b00;

endmodule

// File: tb/tb_neo_sma_cfg.sv
// Bench for neo_sma_cfg: directed scenarios plus randomized bus traffic against a transaction-level model.
module tb_neo_sma_cfg;

  logic        clk, reset;
  logic [18:0] m68k_addr;
  logic [15:0] m68k_din, dout, prom_data;
  logic [1:0]  doe, bank_state;
  logic        n_oel, n_oeu, n_wel, n_weu;
  logic        cfg_we;
  logic [6:0]  cfg_addr;
  logic [23:0] cfg_data, p2_addr;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [23:0] m_map [64];
  logic [23:0] m_bank;
  logic [18:0] m_bank_addr, m_id_addr, m_rng1, m_rng2;
  logic [15:0] m_id_val, m_rng;
  logic [3:0]  m_sel [6];
  bit          m_en;
  logic [15:0] tp_rng [3];

  neo_sma_cfg dut (
    .CLK_24M(clk), .RESET(reset), .M68K_ADDR(m68k_addr), .M68K_DIN(m68k_din),
    .M68K_DOUT(dout), .M68K_DOE(doe), .PROM_DATA(prom_data),
    .nPORTOEL(n_oel), .nPORTOEU(n_oeu), .nPORTWEL(n_wel), .nPORTWEU(n_weu),
    .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data),
    .P2_ADDR(p2_addr), .BANK_BUSY(busy), .BANK_STATE(bank_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr(input logic [15:0] v);
    return {v[14:0], ^(v & 16'h98EC)};
  endfunction

  function automatic logic [5:0] idx_of(input logic [15:0] din);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = din[m_sel[k]];
    return r;
  endfunction

  function automatic logic [23:0] p2_exp(input logic [18:0] a);
    logic [23:0] off;
    off = {4'b0, a, 1'b0};
    return m_en ? m_bank + off : off;
  endfunction

  function automatic logic [15:0] exp_dout(input logic [18:0] a, input logic [15:0] prom);
    if (a == m_id_addr) return m_id_val;
`ifdef SMA_RNG_EN
    if (a == m_rng1 || a == m_rng2) return m_rng;
`endif
    return prom;
  endfunction

  function automatic void model_reset();
    m_en = 0; m_bank = '0; m_bank_addr = '0; m_id_addr = '0; m_id_val = '0;
    m_rng1 = '0; m_rng2 = '0; m_rng = 16'h2345;
    for (int k = 0; k < 6; k++) m_sel[k] = '0;
  endfunction

  function automatic void model_cfg(input logic [6:0] a, input logic [23:0] d);
    if (a < 7'h40) m_map[a[5:0]] = d;
    case (a)
      7'h40: m_bank_addr = d[18:0];
`ifdef SMA_RNG_EN
      7'h41: m_rng1 = d[18:0];
      7'h42: m_rng2 = d[18:0];
`endif
      7'h43: m_id_addr = d[18:0];
      7'h44: m_id_val = d[15:0];
      7'h45: for (int k = 0; k < 6; k++) m_sel[k] = d[4*k +: 4];
      7'h46: m_en = d[0];
      default: ;
    endcase
  endfunction

  task automatic cfg_wr(input logic [6:0] a, input logic [23:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick;
    cfg_we = 0;
    model_cfg(a, d);
  endtask

  task automatic do_reset(input bit with_cfg);
    reset = 1;
    if (with_cfg) begin
      cfg_we = 1; cfg_addr = 7'h46; cfg_data = 24'h1;
    end
    tick;
    reset = 0; cfg_we = 0;
    model_reset();
  endtask

  // Index bits {k5..k0} come from DIN bits {14,8,12,10,5,6}.
  task automatic base_cfg;
    cfg_wr(7'h40, 24'h07FFF8);
    cfg_wr(7'h45, 24'hE8CA56);
    cfg_wr(7'h43, 24'h07F223);
    cfg_wr(7'h44, 24'h009A37);
    cfg_wr(7'h41, 24'h07FFFC);
    cfg_wr(7'h42, 24'h07FFFE);
    cfg_wr(7'h46, 24'h000001);
  endtask

  task automatic p2_chk(input logic [18:0] a);
    m68k_addr = a;
    #1;
    chk("p2_addr", p2_addr, p2_exp(a));
  endtask

  task automatic p2_read(input logic [18:0] a, input bit oel, input bit oeu, output logic [15:0] seen);
    logic [15:0] prom;
    prom = 16'($urandom);
    m68k_addr = a; n_oel = oel; n_oeu = oeu; prom_data = prom;
    tick;
`ifdef SMA_RNG_EN
    if (m_en && !(oel && oeu)) m_rng = lfsr(m_rng);
`endif
    @(negedge clk);
    chk("doe", doe, m_en ? {~oeu, ~oel} : 2'b00);
    chk("dout", dout, exp_dout(a, prom));
    seen = dout;
    tick;
    n_oel = 1; n_oeu = 1;
    tick;
  endtask

  task automatic bank_write(input logic [15:0] din, input bit cfg_same, input logic [23:0] cfg_val);
    logic [5:0]  idx;
    logic [18:0] a;
    int          which;
    idx = idx_of(din);
    which = $urandom_range(0, 2);
    m68k_addr = m_bank_addr; m68k_din = din;
    n_wel = (which == 1); n_weu = (which == 2);
    if (cfg_same) begin
      cfg_we = 1; cfg_addr = {1'b0, idx}; cfg_data = cfg_val;
    end
    @(negedge clk);
    chk("busy_start", busy, m_en);
    tick;
    cfg_we = 0; n_wel = 1; n_weu = 1;
    if (m_en) m_bank = m_map[idx];
    if (cfg_same) m_map[idx] = cfg_val;
    @(negedge clk);
    chk("busy_lookup", busy, m_en);
    tick;
    a = 19'($urandom);
    m68k_addr = a;
    @(negedge clk);
    chk("busy_commit", busy, 1'b0);
    chk("p2_commit", p2_addr, p2_exp(a));
    tick;
  endtask

  initial begin
    logic [15:0] seen, din;
    int busy_cnt;
    tp_rng = '{16'h468A, 16'h8D14, 16'h1A29};
    reset = 1; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
    m68k_addr = '0; m68k_din = '0; prom_data = '0;
    n_oel = 1; n_oeu = 1; n_wel = 1; n_weu = 1;
    model_reset();
    tick; tick;

    // Reset state, with reset overriding a simultaneous ENABLE write
    do_reset(1);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    p2_chk(19'h12345);
    p2_read(19'h00000, 0, 0, seen);
    p2_read(19'h7FFFC, 0, 0, seen);

    for (int i = 0; i < 64; i++) cfg_wr(7'(i), 24'($urandom));
    cfg_wr(7'h47, 24'hFFFFFF);
    cfg_wr(7'h7F, 24'hFFFFFF);

    // Directed bank switch: DIN 0x0440 scrambles to index 5
    cfg_wr(7'h05, 24'h4CC000);
    base_cfg();
    chk("tp_idx", idx_of(16'h0440), 6'd5);
    bank_write(16'h0440, 0, '0);
    p2_chk(19'h0);
    chk("tp_bank", p2_addr, 24'h4CC000);

    // ID register with both and single byte enables
    p2_read(19'h7F223, 0, 0, seen);
    chk("tp_id", seen, 16'h9A37);
    p2_read(19'h7F223, 0, 1, seen);

`ifdef SMA_RNG_EN
    do_reset(0);
    cfg_wr(7'h41, 24'h07FFFC);
    cfg_wr(7'h46, 24'h1);
    for (int i = 0; i < 3; i++) begin
      p2_read(19'h7FFFC, 0, 0, seen);
      chk("tp_rng", seen, tp_rng[i]);
    end
    do_reset(0);
    cfg_wr(7'h41, 24'h07FFFC);
    cfg_wr(7'h46, 24'h1);
    p2_read(19'h7FFFC, 0, 0, seen);
    chk("tp_rng_rst", seen, 16'h468A);
`endif

    // Back-to-back writes: second lands in COMMIT and waits in the pending slot
    base_cfg();
    cfg_wr(7'h01, 24'h111000);
    cfg_wr(7'h03, 24'h333000);
    busy_cnt = 0;
    m68k_addr = m_bank_addr;
    for (int c = 0; c < 8; c++) begin
      n_wel = !(c == 0 || c == 2);
      m68k_din = (c < 2) ? 16'h0040 : 16'h0060;
      @(negedge clk);
      busy_cnt += int'(busy);
      tick;
    end
    n_wel = 1;
    m_bank = m_map[3];
    chk("pend_busy_cycles", busy_cnt, 4);
    p2_chk(19'h0);

    // Reset during LOOKUP aborts the switch; map contents survive
    din = 16'($urandom);
    m68k_addr = m_bank_addr; m68k_din = din; n_wel = 0;
    tick;
    reset = 1; n_wel = 1;
    tick;
    reset = 0;
    model_reset();
    @(negedge clk);
    chk("rst_lookup_busy", busy, 1'b0);
    p2_chk(19'h2ABCD);
    base_cfg();
    bank_write(din, 0, '0);

    // Disabled: no bank switch, no byte enables, RNG frozen
    cfg_wr(7'h46, 24'h0);
    bank_write(16'($urandom), 0, '0);
    p2_read(19'h7FFFC, 0, 0, seen);
    p2_read(19'h7FFF8, 0, 0, seen);
    cfg_wr(7'h46, 24'h1);
    p2_read(19'h7FFFC, 0, 0, seen);

    // Same-cycle map write to the entry being looked up
    bank_write(16'h0440, 1, 24'hABC000);
    bank_write(16'h0440, 0, '0);

    for (int it = 0; it < 400; it++) begin
      int op;
      logic [18:0] ra;
      op = $urandom_range(0, 19);
      case ($urandom_range(0, 4))
        0: ra = m_id_addr;
        1: ra = m_rng1;
        2: ra = m_rng2;
        3: ra = m_bank_addr;
        default: ra = 19'($urandom);
      endcase
      if (op < 5) bank_write(16'($urandom), $urandom_range(0, 3) == 0, 24'($urandom));
      else if (op < 10) p2_read(ra, 1'($urandom), 1'($urandom), seen);
      else if (op < 13) cfg_wr(7'($urandom_range(0, 63)), 24'($urandom));
      else if (op < 16) cfg_wr(7'($urandom_range(64, 127)), 24'($urandom));
      else if (op < 18) cfg_wr(7'h46, 24'h1);
      else if (op < 19) p2_chk(19'($urandom));
      else begin
        do_reset($urandom_range(0, 1) == 1);
        base_cfg();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
